// File: rtl/booth_pp_if.sv
// Request/response bundle between the Booth encoder stage and the partial-product accumulator.
interface booth_pp_if;
  localparam int unsigned REG_W  = 64;
  localparam int unsigned DIG_N  = REG_W / 2;
  localparam int unsigned PROD_W = 2 * REG_W;

  logic              valid_i;
  logic              ready_o;
  logic [REG_W-1:0]  multiplicand_i;
  logic              mcand_signed_i;
  logic [DIG_N-1:0]  zero_index_i;
  logic [DIG_N-1:0]  invert_index_i;
  logic [DIG_N-1:0]  double_index_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [PROD_W-1:0] product_o;

  modport slave (
    input  valid_i, multiplicand_i, mcand_signed_i, zero_index_i,
           invert_index_i, double_index_i, flush_i, ready_i,
    output ready_o, valid_o, product_o
  );

  modport master (
    output valid_i, multiplicand_i, mcand_signed_i, zero_index_i,
           invert_index_i, double_index_i, flush_i, ready_i,
    input  ready_o, valid_o, product_o
  );
endinterface

// File: rtl/booth_pp_accum.sv
// Sequential radix-4 Booth accumulator: one partial product per cycle over 32 digits,
// yielding the 128-bit product of signed(Q) and the (signed or unsigned) multiplicand.
module booth_pp_accum (
  input logic        clk,
  input logic        rst,
  booth_pp_if.slave  bus
);
  localparam int unsigned REG_W  = 64;
  localparam int unsigned DIG_N  = REG_W / 2;
  localparam int unsigned PROD_W = 2 * REG_W;
  localparam int unsigned EXT_W  = PROD_W + 2;
  localparam int unsigned K_W    = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [REG_W-1:0]  mcand_q, mcand_d;
  logic              sgn_q, sgn_d;
  logic [DIG_N-1:0]  zero_q, zero_d;
  logic [DIG_N-1:0]  inv_q, inv_d;
  logic [DIG_N-1:0]  dbl_q, dbl_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              last_q, last_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  logic [EXT_W-1:0]  mext_c, mag_c, pp_c;
  logic [PROD_W-1:0] pp_sh_c;

  // Partial product of digit k, aligned to weight 4^k
  always_comb begin
    mext_c = sgn_q ? {{(EXT_W-REG_W){mcand_q[REG_W-1]}}, mcand_q}
                   : {{(EXT_W-REG_W){1'b0}}, mcand_q};
    if (zero_q[k_q])      mag_c = '0;
    else if (dbl_q[k_q])  mag_c = mext_c << 1;
    else                  mag_c = mext_c;
    pp_c    = (inv_q[k_q] && !zero_q[k_q]) ? (~mag_c + EXT_W'(1)) : mag_c;
    pp_sh_c = PROD_W'(pp_c) << {k_q, 1'b0};
  end

  // Next state; last_q adds the cycle between the final accumulation and DONE
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    sgn_d   = sgn_q;
    zero_d  = zero_q;
    inv_d   = inv_q;
    dbl_d   = dbl_q;
    k_d     = k_q;
    last_d  = last_q;
    acc_d   = acc_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_i && ready_q) begin
            mcand_d = bus.multiplicand_i;
            sgn_d   = bus.mcand_signed_i;
            zero_d  = bus.zero_index_i;
            inv_d   = bus.invert_index_i;
            dbl_d   = bus.double_index_i;
            acc_d   = '0;
            k_d     = '0;
            last_d  = 1'b0;
            state_d = CALC;
          end
        end
        CALC: begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            acc_d  = acc_q + pp_sh_c;
            k_d    = k_q + K_W'(1);
            last_d = (k_q == K_W'(DIG_N - 1));
          end
        end
        DONE: begin
          if (bus.ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      sgn_q   <= 1'b0;
      zero_q  <= '0;
      inv_q   <= '0;
      dbl_q   <= '0;
      k_q     <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      sgn_q   <= sgn_d;
      zero_q  <= zero_d;
      inv_q   <= inv_d;
      dbl_q   <= dbl_d;
      k_q     <= k_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.ready_o   = ready_q;
  assign bus.product_o = acc_q;
endmodule
